// File: rtl/ct_mmu_sysmap_req.sv
// ============================================================================
// Module      : ct_mmu_sysmap_req
// Description : Arbitrates walker/refill sysmap attribute lookups, one request
//               in flight. Optional last-result cache: MMU_SYSMAP_LAST_CACHE_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ct_mmu_sysmap_req #(
    parameter int                   ADDR_WIDTH = 28,
    parameter int                   FLG_WIDTH  = 5,
    parameter logic [FLG_WIDTH-1:0] MISS_FLG   = 5'b10011
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  ptw_sysmap_req_vld,
    input  logic [ADDR_WIDTH-1:0] ptw_sysmap_req_pa,
    output logic                  sysmap_ptw_req_rdy,
    input  logic                  tlb_sysmap_req_vld,
    input  logic [ADDR_WIDTH-1:0] tlb_sysmap_req_pa,
    output logic                  sysmap_tlb_req_rdy,
    output logic [ADDR_WIDTH-1:0] mmu_sysmap_pa_y,
    input  logic [FLG_WIDTH-1:0]  sysmap_mmu_flg_y,
    input  logic [7:0]            sysmap_mmu_hit_y,
    input  logic                  cp0_mmu_sysmap_upd,
    output logic                  sysmap_ptw_rsp_vld,
    output logic                  sysmap_tlb_rsp_vld,
    input  logic                  ptw_sysmap_rsp_rdy,
    input  logic                  tlb_sysmap_rsp_rdy,
    output logic [FLG_WIDTH-1:0]  sysmap_rsp_flg,
    output logic [2:0]            sysmap_rsp_idx,
    output logic                  sysmap_rsp_miss
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LKUP = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;

    logic [1:0]            r_state;
    logic                  r_rr_tlb;
    logic                  r_owner_tlb;
    logic [ADDR_WIDTH-1:0] r_pa;
    logic [FLG_WIDTH-1:0]  r_flg;
    logic [2:0]            r_idx;
    logic                  r_miss;

    logic                  w_idle;
    logic                  w_grant_tlb;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_acc_pa;
    logic                  w_onehot;
    logic [2:0]            w_hit_idx;
    logic [FLG_WIDTH-1:0]  w_lk_flg;
    logic [2:0]            w_lk_idx;
    logic                  w_lk_miss;
    logic                  w_rsp_take;
    logic                  w_cache_hit;
    logic [FLG_WIDTH-1:0]  w_cache_flg;
    logic [2:0]            w_cache_idx;
    logic                  w_cache_miss;

    // The pointer only breaks ties; a lone requester always wins.
    always_comb begin
        w_idle             = (r_state == ST_IDLE);
        w_grant_tlb        = tlb_sysmap_req_vld & (~ptw_sysmap_req_vld | r_rr_tlb);
        sysmap_ptw_req_rdy = ~cpurst & w_idle & ptw_sysmap_req_vld & ~w_grant_tlb;
        sysmap_tlb_req_rdy = ~cpurst & w_idle & w_grant_tlb;
        w_accept           = sysmap_ptw_req_rdy | sysmap_tlb_req_rdy;
        w_acc_pa           = w_grant_tlb ? tlb_sysmap_req_pa : ptw_sysmap_req_pa;
    end

    always_comb begin
        w_onehot  = (|sysmap_mmu_hit_y) &&
                    ((sysmap_mmu_hit_y & (sysmap_mmu_hit_y - 8'd1)) == 8'd0);
        w_hit_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (sysmap_mmu_hit_y[i]) begin
                w_hit_idx = 3'(i);
            end
        end
        w_lk_flg  = w_onehot ? sysmap_mmu_flg_y : MISS_FLG;
        w_lk_idx  = w_onehot ? w_hit_idx : 3'd0;
        w_lk_miss = ~w_onehot;
    end

    always_comb begin
        w_rsp_take         = (r_state == ST_RSP) &
                             (r_owner_tlb ? tlb_sysmap_rsp_rdy : ptw_sysmap_rsp_rdy);
        sysmap_ptw_rsp_vld = ~cpurst & (r_state == ST_RSP) & ~r_owner_tlb;
        sysmap_tlb_rsp_vld = ~cpurst & (r_state == ST_RSP) & r_owner_tlb;
        mmu_sysmap_pa_y    = r_pa;
        sysmap_rsp_flg     = r_flg;
        sysmap_rsp_idx     = r_idx;
        sysmap_rsp_miss    = r_miss;
    end

`ifdef MMU_SYSMAP_LAST_CACHE_EN
    logic                  r_c_vld;
    logic [ADDR_WIDTH-1:0] r_c_pa;
    logic [FLG_WIDTH-1:0]  r_c_flg;
    logic [2:0]            r_c_idx;
    logic                  r_c_miss;

    // A CSR write in the accept cycle must not be answered from stale data.
    always_comb begin
        w_cache_hit  = r_c_vld & ~cp0_mmu_sysmap_upd & (r_c_pa == w_acc_pa);
        w_cache_flg  = r_c_flg;
        w_cache_idx  = r_c_idx;
        w_cache_miss = r_c_miss;
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_c_vld  <= 1'b0;
            r_c_pa   <= '0;
            r_c_flg  <= '0;
            r_c_idx  <= 3'd0;
            r_c_miss <= 1'b0;
        end else if (r_state == ST_LKUP) begin
            r_c_vld  <= ~cp0_mmu_sysmap_upd;
            r_c_pa   <= r_pa;
            r_c_flg  <= w_lk_flg;
            r_c_idx  <= w_lk_idx;
            r_c_miss <= w_lk_miss;
        end else if (cp0_mmu_sysmap_upd) begin
            r_c_vld  <= 1'b0;
        end
    end
`else
    logic w_unused_upd;

    always_comb begin
        w_unused_upd = cp0_mmu_sysmap_upd;
        w_cache_hit  = 1'b0;
        w_cache_flg  = '0;
        w_cache_idx  = 3'd0;
        w_cache_miss = 1'b0;
    end
`endif

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_state     <= ST_IDLE;
            r_rr_tlb    <= 1'b0;
            r_owner_tlb <= 1'b0;
            r_pa        <= '0;
            r_flg       <= '0;
            r_idx       <= 3'd0;
            r_miss      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_pa        <= w_acc_pa;
                        r_owner_tlb <= w_grant_tlb;
                        r_rr_tlb    <= ~w_grant_tlb;
                        if (w_cache_hit) begin
                            r_flg   <= w_cache_flg;
                            r_idx   <= w_cache_idx;
                            r_miss  <= w_cache_miss;
                            r_state <= ST_RSP;
                        end else begin
                            r_state <= ST_LKUP;
                        end
                    end
                end
                ST_LKUP: begin
                    r_flg   <= w_lk_flg;
                    r_idx   <= w_lk_idx;
                    r_miss  <= w_lk_miss;
                    r_state <= ST_RSP;
                end
                ST_RSP: begin
                    if (w_rsp_take) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ct_mmu_sysmap_req.sv
// ============================================================================
// Module      : tb_ct_mmu_sysmap_req
// Description : Directed self-checking bench for ct_mmu_sysmap_req.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ct_mmu_sysmap_req;

    localparam int AW = 28;
    localparam int FW = 5;

    logic          forever_cpuclk = 1'b0;
    logic          cpurst = 1'b1;
    logic          ptw_sysmap_req_vld = 1'b0;
    logic [AW-1:0] ptw_sysmap_req_pa = '0;
    logic          sysmap_ptw_req_rdy;
    logic          tlb_sysmap_req_vld = 1'b0;
    logic [AW-1:0] tlb_sysmap_req_pa = '0;
    logic          sysmap_tlb_req_rdy;
    logic [AW-1:0] mmu_sysmap_pa_y;
    logic [FW-1:0] sysmap_mmu_flg_y = '0;
    logic [7:0]    sysmap_mmu_hit_y = '0;
    logic          cp0_mmu_sysmap_upd = 1'b0;
    logic          sysmap_ptw_rsp_vld;
    logic          sysmap_tlb_rsp_vld;
    logic          ptw_sysmap_rsp_rdy = 1'b0;
    logic          tlb_sysmap_rsp_rdy = 1'b0;
    logic [FW-1:0] sysmap_rsp_flg;
    logic [2:0]    sysmap_rsp_idx;
    logic          sysmap_rsp_miss;

    int n_cmp = 0;
    int n_err = 0;

    always #5 forever_cpuclk = ~forever_cpuclk;

    ct_mmu_sysmap_req dut (
        .forever_cpuclk     (forever_cpuclk),
        .cpurst             (cpurst),
        .ptw_sysmap_req_vld (ptw_sysmap_req_vld),
        .ptw_sysmap_req_pa  (ptw_sysmap_req_pa),
        .sysmap_ptw_req_rdy (sysmap_ptw_req_rdy),
        .tlb_sysmap_req_vld (tlb_sysmap_req_vld),
        .tlb_sysmap_req_pa  (tlb_sysmap_req_pa),
        .sysmap_tlb_req_rdy (sysmap_tlb_req_rdy),
        .mmu_sysmap_pa_y    (mmu_sysmap_pa_y),
        .sysmap_mmu_flg_y   (sysmap_mmu_flg_y),
        .sysmap_mmu_hit_y   (sysmap_mmu_hit_y),
        .cp0_mmu_sysmap_upd (cp0_mmu_sysmap_upd),
        .sysmap_ptw_rsp_vld (sysmap_ptw_rsp_vld),
        .sysmap_tlb_rsp_vld (sysmap_tlb_rsp_vld),
        .ptw_sysmap_rsp_rdy (ptw_sysmap_rsp_rdy),
        .tlb_sysmap_rsp_rdy (tlb_sysmap_rsp_rdy),
        .sysmap_rsp_flg     (sysmap_rsp_flg),
        .sysmap_rsp_idx     (sysmap_rsp_idx),
        .sysmap_rsp_miss    (sysmap_rsp_miss)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge forever_cpuclk);
        #1;
    endtask

    task automatic do_reset;
        cpurst             = 1'b1;
        ptw_sysmap_req_vld = 1'b1;
        tlb_sysmap_req_vld = 1'b1;
        ptw_sysmap_rsp_rdy = 1'b0;
        tlb_sysmap_rsp_rdy = 1'b0;
        tick;
        tick;
        check_val("rst_ptw_rdy", 32'(sysmap_ptw_req_rdy), 32'd0);
        check_val("rst_tlb_rdy", 32'(sysmap_tlb_req_rdy), 32'd0);
        check_val("rst_rsp_vld", 32'({sysmap_ptw_rsp_vld, sysmap_tlb_rsp_vld}), 32'd0);
        check_val("rst_pa", 32'(mmu_sysmap_pa_y), 32'd0);
        check_val("rst_res", 32'({sysmap_rsp_flg, sysmap_rsp_idx, sysmap_rsp_miss}), 32'd0);
        ptw_sysmap_req_vld = 1'b0;
        tlb_sysmap_req_vld = 1'b0;
        cpurst             = 1'b0;
        tick;
    endtask

    // One complete transaction from a single requester, response taken at once.
    task automatic run_req(input bit use_tlb, input logic [AW-1:0] pa, input bit upd,
                           input int exp_lat, input logic [FW-1:0] eflg,
                           input logic [2:0] eidx, input logic emiss, input string tag);
        int lat;
        if (use_tlb) begin
            tlb_sysmap_req_vld = 1'b1;
            tlb_sysmap_req_pa  = pa;
        end else begin
            ptw_sysmap_req_vld = 1'b1;
            ptw_sysmap_req_pa  = pa;
        end
        cp0_mmu_sysmap_upd = upd;
        #1;
        check_val({tag, "_rdy"}, 32'(use_tlb ? sysmap_tlb_req_rdy : sysmap_ptw_req_rdy), 32'd1);
        tick;
        ptw_sysmap_req_vld = 1'b0;
        tlb_sysmap_req_vld = 1'b0;
        cp0_mmu_sysmap_upd = 1'b0;
        #1;
        check_val({tag, "_pa"}, 32'(mmu_sysmap_pa_y), 32'(pa));
        lat = 1;
        while (!(use_tlb ? sysmap_tlb_rsp_vld : sysmap_ptw_rsp_vld) && lat < 8) begin
            tick;
            lat++;
        end
        check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_val({tag, "_other_vld"}, 32'(use_tlb ? sysmap_ptw_rsp_vld : sysmap_tlb_rsp_vld), 32'd0);
        check_val({tag, "_flg"}, 32'(sysmap_rsp_flg), 32'(eflg));
        check_val({tag, "_idx"}, 32'(sysmap_rsp_idx), 32'(eidx));
        check_val({tag, "_miss"}, 32'(sysmap_rsp_miss), 32'(emiss));
        if (use_tlb) tlb_sysmap_rsp_rdy = 1'b1;
        else         ptw_sysmap_rsp_rdy = 1'b1;
        tick;
        ptw_sysmap_rsp_rdy = 1'b0;
        tlb_sysmap_rsp_rdy = 1'b0;
        #1;
        check_val({tag, "_done"}, 32'({sysmap_ptw_rsp_vld, sysmap_tlb_rsp_vld}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        tick;
        do_reset;

        // Single walker request with a one-hot hit.
        sysmap_mmu_hit_y = 8'b0000_0100;
        sysmap_mmu_flg_y = 5'b01101;
        run_req(1'b0, 28'h0001234, 1'b0, 2, 5'b01101, 3'd2, 1'b0, "basic");

        // Walker was granted last, so a tie now goes to the refill side.
        ptw_sysmap_req_vld = 1'b1;
        ptw_sysmap_req_pa  = 28'h0000111;
        tlb_sysmap_req_vld = 1'b1;
        tlb_sysmap_req_pa  = 28'h0000222;
        #1;
        check_val("rr_ptw_rdy", 32'(sysmap_ptw_req_rdy), 32'd0);
        check_val("rr_tlb_rdy", 32'(sysmap_tlb_req_rdy), 32'd1);
        ptw_sysmap_req_vld = 1'b0;
        sysmap_mmu_hit_y   = 8'h80;
        sysmap_mmu_flg_y   = 5'b00001;
        run_req(1'b1, 28'h0000222, 1'b0, 2, 5'b00001, 3'd7, 1'b0, "tlb_idx7");

        sysmap_mmu_hit_y = 8'h00;
        run_req(1'b0, 28'h0FFFFFF, 1'b0, 2, 5'b10011, 3'd0, 1'b1, "nohit");
        sysmap_mmu_hit_y = 8'b0010_0100;
        sysmap_mmu_flg_y = 5'b01111;
        run_req(1'b1, 28'h0000333, 1'b0, 2, 5'b10011, 3'd0, 1'b1, "multihit");

        // Simultaneous requests right after reset.
        do_reset;
        sysmap_mmu_hit_y   = 8'b0000_0010;
        sysmap_mmu_flg_y   = 5'b11000;
        ptw_sysmap_req_vld = 1'b1;
        ptw_sysmap_req_pa  = 28'h00AAAAA;
        tlb_sysmap_req_vld = 1'b1;
        tlb_sysmap_req_pa  = 28'h0055555;
        #1;
        check_val("both_ptw_rdy", 32'(sysmap_ptw_req_rdy), 32'd1);
        check_val("both_tlb_rdy", 32'(sysmap_tlb_req_rdy), 32'd0);
        tick;
        ptw_sysmap_req_vld = 1'b0;
        #1;
        check_val("both_pa1", 32'(mmu_sysmap_pa_y), 32'h00AAAAA);
        check_val("both_lkup_tlb_rdy", 32'(sysmap_tlb_req_rdy), 32'd0);
        tick;
        check_val("both_ptw_rsp", 32'(sysmap_ptw_rsp_vld), 32'd1);
        check_val("both_tlb_rsp0", 32'(sysmap_tlb_rsp_vld), 32'd0);
        check_val("both_idx", 32'(sysmap_rsp_idx), 32'd1);
        tlb_sysmap_rsp_rdy = 1'b1;
        tick;
        tlb_sysmap_rsp_rdy = 1'b0;
        #1;
        check_val("nonowner_rdy_ignored", 32'(sysmap_ptw_rsp_vld), 32'd1);
        ptw_sysmap_rsp_rdy = 1'b1;
        #1;
        check_val("handshake_cycle_tlb_rdy", 32'(sysmap_tlb_req_rdy), 32'd0);
        tick;
        ptw_sysmap_rsp_rdy = 1'b0;
        #1;
        check_val("both_second_tlb_rdy", 32'(sysmap_tlb_req_rdy), 32'd1);
        check_val("both_ptw_rsp_done", 32'(sysmap_ptw_rsp_vld), 32'd0);
        tick;
        tlb_sysmap_req_vld = 1'b0;
        #1;
        check_val("both_pa2", 32'(mmu_sysmap_pa_y), 32'h0055555);
        tick;
        check_val("both_tlb_rsp", 32'(sysmap_tlb_rsp_vld), 32'd1);
        check_val("both_ptw_rsp0", 32'(sysmap_ptw_rsp_vld), 32'd0);
        tlb_sysmap_rsp_rdy = 1'b1;
        tick;
        tlb_sysmap_rsp_rdy = 1'b0;
        #1;
        check_val("both_tlb_done", 32'(sysmap_tlb_rsp_vld), 32'd0);

        // Owner stalls the response while the sysmap inputs change underneath.
        sysmap_mmu_hit_y   = 8'b0000_1000;
        sysmap_mmu_flg_y   = 5'b00111;
        ptw_sysmap_req_vld = 1'b1;
        ptw_sysmap_req_pa  = 28'h0BEEF00;
        #1;
        check_val("stall_acc_rdy", 32'(sysmap_ptw_req_rdy), 32'd1);
        tick;
        ptw_sysmap_req_vld = 1'b0;
        tlb_sysmap_req_vld = 1'b1;
        tlb_sysmap_req_pa  = 28'h0000F0F;
        tick;
        sysmap_mmu_hit_y = 8'h01;
        sysmap_mmu_flg_y = 5'b11111;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val("stall_vld", 32'(sysmap_ptw_rsp_vld), 32'd1);
            check_val("stall_res", 32'({sysmap_rsp_flg, sysmap_rsp_idx, sysmap_rsp_miss}),
                      32'({5'b00111, 3'd3, 1'b0}));
            check_val("stall_req_rdy", 32'({sysmap_ptw_req_rdy, sysmap_tlb_req_rdy}), 32'd0);
            tick;
        end
        ptw_sysmap_rsp_rdy = 1'b1;
        tick;
        ptw_sysmap_rsp_rdy = 1'b0;
        run_req(1'b1, 28'h0000F0F, 1'b0, 2, 5'b11111, 3'd0, 1'b0, "pending");

        // Reset while a lookup is in flight.
        ptw_sysmap_req_vld = 1'b1;
        ptw_sysmap_req_pa  = 28'h0123456;
        tick;
        ptw_sysmap_req_vld = 1'b0;
        cpurst             = 1'b1;
        tick;
        cpurst = 1'b0;
        #1;
        check_val("lkrst_pa", 32'(mmu_sysmap_pa_y), 32'd0);
        check_val("lkrst_res", 32'({sysmap_rsp_flg, sysmap_rsp_idx, sysmap_rsp_miss}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check_val("lkrst_no_rsp", 32'({sysmap_ptw_rsp_vld, sysmap_tlb_rsp_vld}), 32'd0);
            tick;
        end
        sysmap_mmu_hit_y = 8'b0100_0000;
        sysmap_mmu_flg_y = 5'b10101;
        run_req(1'b0, 28'h0123456, 1'b0, 2, 5'b10101, 3'd6, 1'b0, "after_rst");

        // Repeated PA: served from the cache only when it is built in.
        sysmap_mmu_hit_y = 8'b0001_0000;
        sysmap_mmu_flg_y = 5'b01010;
        run_req(1'b0, 28'h0ACE000, 1'b0, 2, 5'b01010, 3'd4, 1'b0, "rep1");
`ifdef MMU_SYSMAP_LAST_CACHE_EN
        sysmap_mmu_flg_y = 5'b00110;
        run_req(1'b0, 28'h0ACE000, 1'b0, 1, 5'b01010, 3'd4, 1'b0, "rep_cached");
        cp0_mmu_sysmap_upd = 1'b1;
        tick;
        cp0_mmu_sysmap_upd = 1'b0;
        run_req(1'b0, 28'h0ACE000, 1'b0, 2, 5'b00110, 3'd4, 1'b0, "rep_after_upd");
        run_req(1'b1, 28'h0ACE000, 1'b0, 1, 5'b00110, 3'd4, 1'b0, "rep_cached2");
        run_req(1'b0, 28'h0ACE000, 1'b1, 2, 5'b00110, 3'd4, 1'b0, "rep_upd_at_acc");
`else
        sysmap_mmu_flg_y = 5'b00110;
        run_req(1'b0, 28'h0ACE000, 1'b0, 2, 5'b00110, 3'd4, 1'b0, "rep_nocache");
        cp0_mmu_sysmap_upd = 1'b1;
        tick;
        cp0_mmu_sysmap_upd = 1'b0;
        run_req(1'b1, 28'h0ACE000, 1'b1, 2, 5'b00110, 3'd4, 1'b0, "rep_upd_ignored");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ct_mmu_sysmap_req.md
CT_MMU_SYSMAP_REQ -- requirements
Module: ct_mmu_sysmap_req

Interface
REQ-001 SHALL take parameter ADDR_WIDTH, default 28, the PA[39:12] page-number width.
REQ-002 SHALL take parameter FLG_WIDTH, default 5, the sysmap attribute flag width.
REQ-003 SHALL take parameter MISS_FLG, default 5'b10011, the flags returned when no sysmap region hits.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 SHALL have ports, in this order:
- forever_cpuclk  in  1  clock
- cpurst  in  1  reset
- ptw_sysmap_req_vld  in  1  page-table-walker request
- ptw_sysmap_req_pa  in  ADDR_WIDTH  walker PA
- sysmap_ptw_req_rdy  out  1  walker request accepted
- tlb_sysmap_req_vld  in  1  TLB-refill request
- tlb_sysmap_req_pa  in  ADDR_WIDTH  refill PA
- sysmap_tlb_req_rdy  out  1  refill request accepted
- mmu_sysmap_pa_y  out  ADDR_WIDTH  PA to sysmap compare
- sysmap_mmu_flg_y  in  FLG_WIDTH  sysmap flags (combinational)
- sysmap_mmu_hit_y  in  8  sysmap region hit vector
- cp0_mmu_sysmap_upd  in  1  one-cycle pulse: sysmap CSR written
- sysmap_ptw_rsp_vld  out  1  response to walker
- sysmap_tlb_rsp_vld  out  1  response to refill
- ptw_sysmap_rsp_rdy  in  1  walker takes response
- tlb_sysmap_rsp_rdy  in  1  refill takes response
- sysmap_rsp_flg  out  FLG_WIDTH  response flags
- sysmap_rsp_idx  out  3  hit region index
- sysmap_rsp_miss  out  1  no single region hit

Function
REQ-006 SHALL have FSM states IDLE, LKUP and RSP, with one request outstanding.
REQ-007 In IDLE, SHALL assert req_rdy only to the arbitration winner; all other req_rdy SHALL be 0.
REQ-008 Arbitration SHALL work as follows:
- a lone valid requester wins;
- if both are valid, the round-robin pointer selects the winner;
- the pointer toggles to the other requester after every grant.
REQ-009 On accept (vld&rdy) in cycle N, SHALL register the PA and the owner, then go to LKUP.
REQ-010 mmu_sysmap_pa_y SHALL always equal the registered PA.
REQ-011 In LKUP, SHALL capture the result at the end of the cycle and go to RSP.
- sysmap_mmu_hit_y one-hot: flags = sysmap_mmu_flg_y, idx = encoded bit, miss = 0.
- Otherwise: flags = MISS_FLG, idx = 0, miss = 1.
REQ-012 In RSP, SHALL assert only the owner's rsp_vld, with flg/idx/miss held stable until the owner's rsp_rdy.
REQ-013 SHALL return to IDLE on rsp_vld&rsp_rdy; no new request is accepted in that cycle, so the minimum issue interval is 3 cycles.
REQ-014 Base latency SHALL be: accept in cycle N, rsp_vld first high in cycle N+2.
REQ-015 The non-owner's rsp_rdy SHALL be ignored, and a request held pending SHALL keep its vld and PA stable until granted.
REQ-016 When cp0_mmu_sysmap_upd arrives in LKUP, the capture SHALL still occur, because the sysmap reflects the new CSR values combinationally.

Reset
REQ-017 While cpurst=1, SHALL force:
- state to IDLE;
- the round-robin pointer to the walker;
- registered PA, flags, idx, miss and both rsp_vld to 0;
- both req_rdy to 0.
REQ-018 Reset in any state SHALL drop the in-flight request with no response, and SHALL clear the last-result cache.
REQ-019 The first accept after reset SHALL be possible in the cycle after cpurst deasserts.

Configuration
REQ-020 With MMU_SYSMAP_LAST_CACHE_EN defined, SHALL keep a one-entry cache: valid bit, PA, flags, idx and miss, written on every LKUP capture.
REQ-021 With the macro defined, a cache hit SHALL skip LKUP:
- a cache hit is an accepted PA equal to the cached PA with the valid bit set;
- the block goes IDLE to RSP with the cached result, so rsp_vld is high in N+1.
REQ-022 With the macro defined, cp0_mmu_sysmap_upd SHALL clear the cache valid bit.
- If the pulse coincides with an accept, the lookup SHALL miss the cache.
- If the pulse coincides with a LKUP capture, the capture SHALL NOT set the valid bit.
REQ-023 Without the macro, there SHALL be no cache storage, every request SHALL go through LKUP, and cp0_mmu_sysmap_upd SHALL be ignored; the port remains.

Verification
REQ-024 Reset is released and the walker requests PA 0x0001234 while hit_y=8'b00000100 and flg_y=5'b01101; the bench SHALL see ptw_rsp_vld in N+2 with flg=5'b01101, idx=2, miss=0.
REQ-025 Both requesters are valid in the same cycle after reset; the bench SHALL see the walker granted first, then the refill, each response reaching only its owner.
REQ-026 A request sees hit_y=8'h00; the bench SHALL see flg=5'b10011, idx=0, miss=1.
REQ-027 The owner holds rsp_rdy=0 for 5 cycles; the bench SHALL see outputs stable, rsp_vld high, and req_rdy=0 throughout.
REQ-028 cpurst is pulsed during LKUP; the bench SHALL see no response, state IDLE, and the next request served normally.
REQ-029 With MMU_SYSMAP_LAST_CACHE_EN, the same PA is repeated; the bench SHALL see a response in N+1. After cp0_mmu_sysmap_upd, the same PA SHALL take N+2.
